// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bc_pkg
//  Description : Shared definitions for the Basic Computer register slice:
//                standard register widths, the command bit layout and the
//                priority-ordered command encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bc_pkg;

    // Standard datapath widths: address-type (AR/PC) and data-type (DR/AC/TR)
    localparam int AR_W = 12;
    localparam int DR_W = 16;

    // Number of register commands
    localparam int CMD_NUM = 6;

    // Bit position of each command in the command vector.
    // A lower index means a higher priority.
    localparam int CMD_BIT_CLR  = 0;
    localparam int CMD_BIT_LOAD = 1;
    localparam int CMD_BIT_INC  = 2;
    localparam int CMD_BIT_DEC  = 3;
    localparam int CMD_BIT_SHL  = 4;
    localparam int CMD_BIT_SHR  = 5;

    // Encoded selected command. The values follow the priority order.
    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_CLR  = 3'd1;
    localparam logic [2:0] CMD_LOAD = 3'd2;
    localparam logic [2:0] CMD_INC  = 3'd3;
    localparam logic [2:0] CMD_DEC  = 3'd4;
    localparam logic [2:0] CMD_SHL  = 3'd5;
    localparam logic [2:0] CMD_SHR  = 3'd6;

    typedef logic [CMD_NUM-1:0] cmd_vec_t;

    // Map a one-hot command vector (at most one bit set) to its encoding
    function automatic logic [2:0] cmd_onehot_to_code(input cmd_vec_t onehot);
        logic [2:0] code;
        code = CMD_NONE;
        if (onehot[CMD_BIT_CLR])  code = CMD_CLR;
        if (onehot[CMD_BIT_LOAD]) code = CMD_LOAD;
        if (onehot[CMD_BIT_INC])  code = CMD_INC;
        if (onehot[CMD_BIT_DEC])  code = CMD_DEC;
        if (onehot[CMD_BIT_SHL])  code = CMD_SHL;
        if (onehot[CMD_BIT_SHR])  code = CMD_SHR;
        return code;
    endfunction

endpackage : bc_pkg
`default_nettype wire

// File: rtl/bc_cmd_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bc_cmd_decode
//  Description : Priority decoder for the register command bits. It returns
//                the winning command as a one-hot vector and as an encoded
//                value, and flags cycles where more than one command is
//                raised. The control unit's register-transfer checker uses
//                the same block.
//  Revision    : 1.0 - initial release
// ============================================================================
module bc_cmd_decode
    import bc_pkg::*;
(
    input  logic [CMD_NUM-1:0] cmd_in,
    output logic [CMD_NUM-1:0] cmd_onehot,
    output logic [2:0]         cmd_code,
    output logic               conflict
);

    // Keep only the lowest-index (highest-priority) asserted command
    always_comb begin
        logic found;
        found      = 1'b0;
        cmd_onehot = '0;
        for (int i = 0; i < CMD_NUM; i++) begin
            if (cmd_in[i] && !found) begin
                cmd_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Encode the winner. A conflict exists when clearing the lowest set bit
    // still leaves some bit set.
    always_comb begin
        cmd_code = cmd_onehot_to_code(cmd_onehot);
        conflict = |(cmd_in & (cmd_in - CMD_NUM'(1)));
    end

endmodule : bc_cmd_decode
`default_nettype wire

// File: rtl/bc_param_register.sv
`default_nettype none
// ============================================================================
//  Module      : bc_param_register
//  Description : Parametrised Basic Computer register with load, inc, dec,
//                clear and rotate-through-E commands. Counting either wraps
//                or saturates. Outputs a combinational zero flag and a
//                sticky flag for conflicting commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module bc_param_register
    import bc_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          IN_WIDTH    = 16,
    parameter int          SATURATE    = 0,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                inc,
    input  logic                dec,
    input  logic                clr,
    input  logic                shl,
    input  logic                shr,
    input  logic [IN_WIDTH-1:0] indata,
    output logic [WIDTH-1:0]    outdata,
    output logic                e_out,
    output logic                zero,
    output logic                cmd_error,
    input  logic                err_clr
);

    localparam logic [WIDTH-1:0] C_RESET_VALUE = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

    logic [WIDTH-1:0]   outdata_q, outdata_d;
    logic               e_q, e_d;
    logic               cmd_error_q, cmd_error_d;

    cmd_vec_t           w_cmd_vec;
    cmd_vec_t           w_cmd_onehot_unused;
    logic [2:0]         w_cmd_code;
    logic               w_conflict;
    logic [WIDTH-1:0]   w_load_data;

    // Assemble the command vector in priority order (bit 0 wins)
    always_comb begin
        w_cmd_vec               = '0;
        w_cmd_vec[CMD_BIT_CLR]  = clr;
        w_cmd_vec[CMD_BIT_LOAD] = load;
        w_cmd_vec[CMD_BIT_INC]  = inc;
        w_cmd_vec[CMD_BIT_DEC]  = dec;
        w_cmd_vec[CMD_BIT_SHL]  = shl;
        w_cmd_vec[CMD_BIT_SHR]  = shr;
    end

    bc_cmd_decode u_cmd_decode (
        .cmd_in     (w_cmd_vec),
        .cmd_onehot (w_cmd_onehot_unused),
        .cmd_code   (w_cmd_code),
        .conflict   (w_conflict)
    );

    // The bus can be wider than the register. The upper bits are dropped
    // without any error indication.
    assign w_load_data = indata[WIDTH-1:0];

    generate
        if (IN_WIDTH > WIDTH) begin : g_bus_wide
            logic w_unused_hi;
            assign w_unused_hi = ^indata[IN_WIDTH-1:WIDTH];
        end
    endgenerate

    // Next-state arithmetic for the register and E. Only one action runs per edge.
    always_comb begin
        outdata_d = outdata_q;
        e_d       = e_q;
        case (w_cmd_code)
            CMD_CLR: begin
                outdata_d = '0;
            end
            CMD_LOAD: begin
                outdata_d = w_load_data;
            end
            CMD_INC: begin
                if (SATURATE != 0) begin
                    // All-ones holds and reports the overflow attempt in E
                    if (&outdata_q) begin
                        e_d = 1'b1;
                    end else begin
                        outdata_d = outdata_q + C_ONE;
                    end
                end else begin
                    outdata_d = outdata_q + C_ONE;
                    if (&outdata_q) begin
                        e_d = 1'b1;
                    end
                end
            end
            CMD_DEC: begin
                if (SATURATE != 0) begin
                    // Zero holds and reports the underflow attempt in E
                    if (outdata_q == '0) begin
                        e_d = 1'b1;
                    end else begin
                        outdata_d = outdata_q - C_ONE;
                    end
                end else begin
                    outdata_d = outdata_q - C_ONE;
                    if (outdata_q == '0) begin
                        e_d = 1'b1;
                    end
                end
            end
            CMD_SHL: begin
                // Rotate left through E (CIL)
                {e_d, outdata_d} = {outdata_q, e_q};
            end
            CMD_SHR: begin
                // Rotate right through E (CIR)
                {outdata_d, e_d} = {e_q, outdata_q};
            end
            default: begin
            end
        endcase
    end

    // Sticky conflict flag. A new conflict wins over a clear on the same edge.
    always_comb begin
        cmd_error_d = cmd_error_q;
        if (w_conflict) begin
            cmd_error_d = 1'b1;
        end else if (err_clr) begin
            cmd_error_d = 1'b0;
        end
    end

    // State registers. Reset is asynchronous and overrides any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outdata_q   <= C_RESET_VALUE;
            e_q         <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            outdata_q   <= outdata_d;
            e_q         <= e_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign outdata   = outdata_q;
    assign e_out     = e_q;
    assign cmd_error = cmd_error_q;
    assign zero      = (outdata_q == '0);

endmodule : bc_param_register
`default_nettype wire

// File: tb/tb_bc_param_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bc_param_register
//  Description : Self-checking bench for bc_param_register. Four instances:
//                0: WIDTH=12 wrap, 1: WIDTH=12 saturate (reset value 0x5A5),
//                2: WIDTH=16 wrap, 3: WIDTH=4 wrap (sequence counter).
//                Table vectors carry expected outputs into a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bc_param_register;

    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_CLR  = 6'b000001;
    localparam logic [5:0] C_LOAD = 6'b000010;
    localparam logic [5:0] C_INC  = 6'b000100;
    localparam logic [5:0] C_DEC  = 6'b001000;
    localparam logic [5:0] C_SHL  = 6'b010000;
    localparam logic [5:0] C_SHR  = 6'b100000;

    typedef struct {
        int          dut;
        logic [5:0]  cmd;
        logic [15:0] din;
        logic        errc;
        logic [15:0] exp_out;
        logic        exp_e;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [5:0]  cmd_v  [4];
    logic [15:0] din_v  [4];
    logic        errc_v [4];

    logic [11:0] out0, out1;
    logic [15:0] out2;
    logic [3:0]  out3;
    logic [3:0]  e_v, z_v, err_v;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];
    vec_t sb_q[$];

    bc_param_register #(.WIDTH(12), .IN_WIDTH(16), .SATURATE(0), .RESET_VALUE(32'h0)) u_r12 (
        .clk(clk), .reset_n(reset_n),
        .load(cmd_v[0][1]), .inc(cmd_v[0][2]), .dec(cmd_v[0][3]), .clr(cmd_v[0][0]),
        .shl(cmd_v[0][4]), .shr(cmd_v[0][5]), .indata(din_v[0]),
        .outdata(out0), .e_out(e_v[0]), .zero(z_v[0]), .cmd_error(err_v[0]), .err_clr(errc_v[0]));

    bc_param_register #(.WIDTH(12), .IN_WIDTH(16), .SATURATE(1), .RESET_VALUE(32'h5A5)) u_r12s (
        .clk(clk), .reset_n(reset_n),
        .load(cmd_v[1][1]), .inc(cmd_v[1][2]), .dec(cmd_v[1][3]), .clr(cmd_v[1][0]),
        .shl(cmd_v[1][4]), .shr(cmd_v[1][5]), .indata(din_v[1]),
        .outdata(out1), .e_out(e_v[1]), .zero(z_v[1]), .cmd_error(err_v[1]), .err_clr(errc_v[1]));

    bc_param_register #(.WIDTH(16), .IN_WIDTH(16), .SATURATE(0), .RESET_VALUE(32'h0)) u_r16 (
        .clk(clk), .reset_n(reset_n),
        .load(cmd_v[2][1]), .inc(cmd_v[2][2]), .dec(cmd_v[2][3]), .clr(cmd_v[2][0]),
        .shl(cmd_v[2][4]), .shr(cmd_v[2][5]), .indata(din_v[2]),
        .outdata(out2), .e_out(e_v[2]), .zero(z_v[2]), .cmd_error(err_v[2]), .err_clr(errc_v[2]));

    bc_param_register #(.WIDTH(4), .IN_WIDTH(16), .SATURATE(0), .RESET_VALUE(32'h0)) u_sc (
        .clk(clk), .reset_n(reset_n),
        .load(cmd_v[3][1]), .inc(cmd_v[3][2]), .dec(cmd_v[3][3]), .clr(cmd_v[3][0]),
        .shl(cmd_v[3][4]), .shr(cmd_v[3][5]), .indata(din_v[3]),
        .outdata(out3), .e_out(e_v[3]), .zero(z_v[3]), .cmd_error(err_v[3]), .err_clr(errc_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] get_out(input int d);
        case (d)
            0:       return {4'h0, out0};
            1:       return {4'h0, out1};
            2:       return out2;
            default: return {12'h0, out3};
        endcase
    endfunction

    function automatic vec_t mk(input int d, input logic [5:0] c, input logic [15:0] di,
                                input logic ec, input logic [15:0] eo, input logic ee,
                                input logic ez, input logic er);
        vec_t v;
        v.dut = d; v.cmd = c; v.din = di; v.errc = ec;
        v.exp_out = eo; v.exp_e = ee; v.exp_zero = ez; v.exp_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare a DUT's full output state against expected values
    task automatic check_state(input string tag, input int d, input logic [15:0] eo,
                               input logic ee, input logic ez, input logic er);
        check({tag, ".out"}, get_out(d), eo);
        check({tag, ".e"},   {15'h0, e_v[d]},   {15'h0, ee});
        check({tag, ".zero"},{15'h0, z_v[d]},   {15'h0, ez});
        check({tag, ".err"}, {15'h0, err_v[d]}, {15'h0, er});
    endtask

    // Drive one vector, push its expectation, pop and compare after the edge
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        cmd_v[v.dut]  = v.cmd;
        din_v[v.dut]  = v.din;
        errc_v[v.dut] = v.errc;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_state($sformatf("vec%0d_dut%0d", idx, e.dut), e.dut, e.exp_out, e.exp_e,
                    e.exp_zero, e.exp_err);
        cmd_v[v.dut]  = C_IDLE;
        errc_v[v.dut] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cmd_v[i] = C_IDLE; din_v[i] = 16'h0; errc_v[i] = 1'b0;
        end
        reset_n = 1'b0;

        // Vector table: dut, cmd, din, err_clr, out, e, zero, err
        // 12-bit wrap: truncating load, wrap on inc, borrow on dec
        tbl.push_back(mk(0, C_LOAD, 16'hABCD, 0, 16'h0BCD, 0, 0, 0));
        tbl.push_back(mk(0, C_LOAD, 16'hFFFF, 0, 16'h0FFF, 0, 0, 0));
        tbl.push_back(mk(0, C_INC,  16'h0,    0, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(0, C_DEC,  16'h0,    0, 16'h0FFF, 1, 0, 0));
        tbl.push_back(mk(0, C_IDLE, 16'h0,    0, 16'h0FFF, 1, 0, 0));
        // 12-bit saturate
        tbl.push_back(mk(1, C_LOAD, 16'h0FFF, 0, 16'h0FFF, 0, 0, 0));
        tbl.push_back(mk(1, C_INC,  16'h0,    0, 16'h0FFF, 1, 0, 0));
        tbl.push_back(mk(1, C_INC,  16'h0,    0, 16'h0FFF, 1, 0, 0));
        tbl.push_back(mk(1, C_INC,  16'h0,    0, 16'h0FFF, 1, 0, 0));
        tbl.push_back(mk(1, C_CLR,  16'h0,    0, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, C_DEC,  16'h0,    0, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, C_INC,  16'h0,    0, 16'h0001, 1, 0, 0));
        // 16-bit: rotates through E, conflicts and sticky flag
        tbl.push_back(mk(2, C_LOAD, 16'h8001, 0, 16'h8001, 0, 0, 0));
        tbl.push_back(mk(2, C_SHL,  16'h0,    0, 16'h0002, 1, 0, 0));
        tbl.push_back(mk(2, C_SHR,  16'h0,    0, 16'h8001, 0, 0, 0));
        tbl.push_back(mk(2, C_LOAD | C_INC, 16'h0005, 0, 16'h0005, 0, 0, 1));
        tbl.push_back(mk(2, C_IDLE, 16'h0,    0, 16'h0005, 0, 0, 1));
        tbl.push_back(mk(2, C_IDLE, 16'h0,    0, 16'h0005, 0, 0, 1));
        tbl.push_back(mk(2, C_IDLE, 16'h0,    1, 16'h0005, 0, 0, 0));
        tbl.push_back(mk(2, C_CLR | C_INC, 16'h0, 1, 16'h0000, 0, 1, 1));
        tbl.push_back(mk(2, C_IDLE, 16'h0,    1, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(2, C_DEC,  16'h0,    0, 16'hFFFF, 1, 0, 0));
        tbl.push_back(mk(2, C_INC | C_DEC | C_SHR, 16'h0, 0, 16'h0000, 1, 1, 1));

        // Reset state (0x5A5 on the saturating instance)
        #12;
        check_state("reset_r12",  0, 16'h0000, 0, 1, 0);
        check_state("reset_r12s", 1, 16'h05A5, 0, 0, 0);
        check_state("reset_r16",  2, 16'h0000, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Sequence counter: 16 increments, 1..15 then wrap to 0 with E set
        for (int i = 1; i <= 16; i++) begin
            apply(mk(3, C_INC, 16'h0, 0, 16'(i % 16), (i == 16), (i == 16), 0), 100 + i);
        end
        apply(mk(3, C_CLR | C_INC, 16'h0,    0, 16'h0000, 1, 1, 1), 200);
        apply(mk(3, C_LOAD,        16'hABCD, 0, 16'h000D, 1, 0, 1), 201);
        apply(mk(3, C_IDLE,        16'h0,    1, 16'h000D, 1, 0, 0), 202);

        // Reset in the middle of a pending load: reset takes effect at once
        // and the load is lost
        @(negedge clk);
        cmd_v[2] = C_LOAD;
        din_v[2] = 16'h1234;
        #2;
        reset_n = 1'b0;
        #1;
        check_state("midreset_r16",  2, 16'h0000, 0, 1, 0);
        check_state("midreset_r12s", 1, 16'h05A5, 0, 0, 0);
        check_state("midreset_sc",   3, 16'h0000, 0, 1, 0);
        @(posedge clk);
        #1;
        check_state("reset_hold_r16", 2, 16'h0000, 0, 1, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        cmd_v[2] = C_IDLE;
        @(posedge clk);
        #1;
        check_state("post_release_r16", 2, 16'h0000, 0, 1, 0);
        apply(mk(2, C_LOAD, 16'h1234, 0, 16'h1234, 0, 0, 0), 300);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bc_param_register
`default_nettype wire

// File: doc/bc_param_register.md
Name: bc_param_register

Overview:
- Parametrised general-purpose register for the Basic Computer datapath; generalises the fixed-width AR/PC-style load/inc/clr registers.
- Adds decrement, shift left/right through a carry (E) bit, selectable wrap or saturate counting, and zero/carry status.
- Adds a sticky error flag for conflicting commands.
- Instantiated as AR/PC (WIDTH=12), as DR/AC/TR (WIDTH=16), and as the sequence counter SC (WIDTH=4, dec unused).

Parameters:
- WIDTH, 16, stored register width in bits (2..32).
- IN_WIDTH, 16, bus input width; low WIDTH bits are loaded, upper bits ignored (IN_WIDTH >= WIDTH).
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc holds at all-ones, dec holds at zero.
- RESET_VALUE, 0, value of outdata after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  load indata[WIDTH-1:0].
- inc  input  1  increment.
- dec  input  1  decrement.
- clr  input  1  synchronous clear to zero.
- shl  input  1  shift left through E.
- shr  input  1  shift right through E.
- indata  input  IN_WIDTH  bus data.
- outdata  output  WIDTH  register contents.
- e_out  output  1  carry/extension bit E.
- zero  output  1  combinational, 1 when outdata == 0.
- cmd_error  output  1  sticky conflicting-command flag.
- err_clr  input  1  clears cmd_error.

Behaviour:
- Reset: reset_n low asynchronously forces outdata=RESET_VALUE, e_out=0, cmd_error=0. Release is synchronous to the next clk edge.
- All other updates occur on the rising edge of clk. Latency is one cycle; outdata reflects the command on the following edge.
- Command priority, highest first: clr, load, inc, dec, shl, shr. Exactly one action executes per edge.
- No command asserted: register holds, E holds.
- clr: outdata=0. E is unchanged.
- load: outdata=indata[WIDTH-1:0]. E is unchanged.
- inc with SATURATE=0:
  - outdata=outdata+1 mod 2^WIDTH.
  - E=1 on wrap from all-ones to 0; E otherwise unchanged.
- inc with SATURATE=1: all-ones holds, and E is set to 1.
- dec with SATURATE=0:
  - outdata=outdata-1 mod 2^WIDTH.
  - E=1 on borrow from 0 to all-ones; E otherwise unchanged.
- dec with SATURATE=1: 0 holds, and E is set to 1.
- shl: {E, outdata} <= {outdata, E}, a rotate through E (Mano CIL).
- shr: {outdata, E} <= {E, outdata}, a rotate through E (Mano CIR).
- cmd_error: set on any edge where more than one of load/inc/dec/clr/shl/shr is high.
  - The prioritised action still executes.
  - err_clr on the same edge as a new conflict: set wins.
  - err_clr alone clears the flag.
- zero is purely combinational from the register; no extra cycle.
- Width rule: IN_WIDTH > WIDTH truncates silently, with no error.
- Reset asserted mid-command: reset dominates and the command is lost.

Decomposition:
- bc_pkg holds:
  - the command priority encoding (localparam CMD_NONE, CMD_CLR, CMD_LOAD, CMD_INC, CMD_DEC, CMD_SHL, CMD_SHR);
  - the standard widths AR_W=12 and DR_W=16.
- One natural sub-module: bc_cmd_decode.
  - Input: the six command bits.
  - Outputs: the one-hot selected command and the multi-command conflict bit.
  - It is reused by the control unit's register-transfer checker.
- Next-state arithmetic stays in the top module.

Test Plan:
- Reset/load:
  - Assert reset_n=0 mid-cycle → outdata=0, e_out=0, cmd_error=0 immediately.
  - Release, then load with indata=16'hABCD at WIDTH=12 → outdata=12'hBCD next edge; zero=0.
- Wrap:
  - WIDTH=12, SATURATE=0, load 12'hFFF, then inc → outdata=12'h000, e_out=1, zero=1.
  - Then dec → outdata=12'hFFF, e_out=1.
- Saturate:
  - SATURATE=1, load all-ones, inc x3 → outdata holds 12'hFFF, e_out=1.
  - clr, then dec → outdata stays 0.
- Shifts:
  - WIDTH=16, load 16'h8001 with E=0, then shl → outdata=16'h0002, e_out=1.
  - Then shr → outdata=16'h8001, e_out=0.
- Conflict:
  - load=1 and inc=1 with indata=16'h0005 → outdata=16'h0005 (load wins), cmd_error=1.
  - Flag stays 1 over idle cycles; err_clr → 0.
  - err_clr concurrent with clr+inc → cmd_error stays 1, outdata=0.
- SC use:
  - WIDTH=4, inc 16 times from 0 → outdata sequence 1..15,0; e_out=1 after the wrap.
  - clr on the same edge as inc → outdata=0.
